cnn_window_framer: RTL
======================

# cnn_window_framer

Receive-side companion to the CNN line buffer (`CNN_windows`). It consumes the per-pixel `taps` column that the line buffer emits: K vertically aligned pixels from the current and previous K-1 image lines. It assembles these into a registered K×K convolution window, tracks image position, and flags only the windows that lie fully inside the image. It sits between the line buffer and the convolution MAC array.

## Interface
- `DW`, 9: pixel width in bits; pixels are treated as opaque bit patterns.
- `K`, 5: window size, K×K.
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `CW`, `$clog2(IMG_W)`, local: column counter width.
- `RW`, `$clog2(IMG_H)`, local: row counter width.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `in_valid`  in  1: `taps` carries a new pixel column this cycle.
- `sof`  in  1: start of frame, qualified by `in_valid`; this beat is pixel (0,0).
- `taps`  in  K*DW: tap i at bits `[(i+1)*DW-1 : i*DW]` is the pixel i lines above the current pixel, same column; tap 0 is the current line.
- `win_valid`  out  1: `win` holds a complete in-image window.
- `win`  out  K*K*DW: element (r,c) at bits `[(r*K+c+1)*DW-1 : (r*K+c)*DW]`; r=0 is the top (oldest) line, c=0 is the left (oldest) column.
- `win_row`  out  RW: output row of the window, equal to its top-left image row.
- `win_col`  out  CW: output column of the window, equal to its top-left image column.
- `frame_done`  out  1: single pulse coincident with the frame's last window.

## Operation
- Column shift register: K columns of K×DW bits each, advanced only on `in_valid`.
  - New column enters at c=K-1; the oldest column is dropped.
  - Window line r takes tap K-1-r.
- Position counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) describe the incoming beat and advance on each `in_valid`.
  - `col` wraps to 0 after IMG_W-1; on that wrap `row` increments.
  - `row` wraps to 0 after IMG_H-1, so back-to-back frames run without `sof`.
  - `sof` with `in_valid` forces the current beat to position (0,0), overriding the counters; the counters continue from there.
- Window qualification: a beat produces a window when `col >= K-1` and `row >= K-1`.
  - The qualifying beat sets `win_row = row-(K-1)` and `win_col = col-(K-1)`.
  - Columns that span a line boundary (col < K-1) are never flagged, even though the shift register holds stale data from the previous line.
- `frame_done` is set on the beat at (IMG_H-1, IMG_W-1).
- Per frame: exactly (IMG_W-K+1)×(IMG_H-K+1) windows, in raster order.
- No backpressure. The downstream block must accept a window on every cycle `win_valid` is high.

## Timing
- Latency: `win`, `win_valid`, `win_row`, `win_col` and `frame_done` are registered, 1 cycle after the qualifying `in_valid` beat.
- `win_valid` and `frame_done` are high for exactly one cycle per qualifying beat.
- With `in_valid` low:
  - `win_valid` and `frame_done` are 0 the next cycle.
  - `win`, `win_row` and `win_col` hold their values.
  - Counters and the shift register do not change.
- Reset: all outputs, counters and the shift register are 0 one cycle after `rst` is sampled high. `rst` overrides a simultaneous `in_valid`/`sof`.
- Reset mid-frame: partial state is discarded; the next `in_valid` beat is position (0,0).
- `sof` arriving mid-frame: the restart takes effect on that beat. No window is emitted until K-1 lines plus K-1 pixels of the new frame have arrived. Any pending window of the old frame is cancelled.

## Configuration
- `CNN_WIN_STRIDE2_EN` defined:
  - `win_valid` is gated additionally by `win_row` even AND `win_col` even (stride 2).
  - `frame_done` still pulses on the beat at (IMG_H-1, IMG_W-1), whether or not that window passes the stride gate.
  - `win`, `win_row` and `win_col` update on every qualifying beat.
- Undefined: stride 1, all in-image windows flagged.

## Test plan
Common setup: IMG_W=8, IMG_H=8, K=5, DW=9. The bench models the line buffer: pixel (y,x) = 16y+x, and tap i = pixel(y-i, x), or 0 when y-i < 0. `sof` is on beat 0.

- **Continuous feed.** 64 consecutive beats → first `win_valid` one cycle after beat 36, with `win_row`=0, `win_col`=0, element (0,0)=0, element (4,4)=68. 16 windows in total. The last window has `win_row`=3, `win_col`=3, element (4,4)=119, and `frame_done` high on the same cycle only.
- **Gapped feed.** `in_valid` toggles every cycle → the same 16 windows with the same contents; `win_valid` is never high on two consecutive cycles; `win` holds between windows.
- **Reset mid-frame.** `rst` for one cycle after beat 40 → all outputs 0 next cycle. After restarting the feed from pixel (0,0), the first window appears one cycle after restart beat 36, with element (4,4)=68.
- **Mid-frame `sof`.** `sof` re-asserted on beat 20, with pixel numbering restarted at that beat → no window for the following 36 beats; then a window with `win_row`=0, `win_col`=0.
- **Two frames back-to-back.** 128 beats with no second `sof` → 32 windows and 2 `frame_done` pulses; the second frame's first window has `win_row`=0, `win_col`=0.
- **Stride 2.** With `CNN_WIN_STRIDE2_EN` defined, 64 beats → exactly 4 windows at (`win_row`,`win_col`) = (0,0),(0,2),(2,0),(2,2). `frame_done` pulses once with `win_valid` low.

Source files
------------

// File: rtl/cnn_window_framer.sv
// Builds a registered KxK window from line-buffer tap columns and flags in-image windows in raster order.
// Optional stride-2 qualification is enabled by defining CNN_WIN_STRIDE2_EN.
module cnn_window_framer #(
  parameter  int DW    = 9,
  parameter  int K     = 5,
  parameter  int IMG_W = 28,
  parameter  int IMG_H = 28,
  localparam int CW    = $clog2(IMG_W),
  localparam int RW    = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              sof,
  input  logic [K*DW-1:0]   taps,
  output logic              win_valid,
  output logic [K*K*DW-1:0] win,
  output logic [RW-1:0]     win_row,
  output logic [CW-1:0]     win_col,
  output logic              frame_done
);

  localparam logic [CW-1:0] ColLast  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] ColFirst = CW'(K - 1);
  localparam logic [RW-1:0] RowFirst = RW'(K - 1);

  logic [K*DW-1:0]   cols_q [K];
  logic [K*DW-1:0]   cols_d [K];
  logic [K*DW-1:0]   newCol;
  logic [CW-1:0]     colCnt_q, colCnt_d, curCol;
  logic [RW-1:0]     rowCnt_q, rowCnt_d, curRow;
  logic              qualify, frameEnd, winValid_d;
  logic [K*K*DW-1:0] win_d, win_q;
  logic [RW-1:0]     winRow_d, winRow_q;
  logic [CW-1:0]     winCol_d, winCol_q;
  logic              winValid_q, frameDone_q;

  always_comb begin
    curCol = sof ? '0 : colCnt_q;
    curRow = sof ? '0 : rowCnt_q;

    // Tap K-1 is the oldest line, so it becomes window line 0.
    newCol = '0;
    for (int r = 0; r < K; r++) begin
      newCol[r*DW +: DW] = taps[(K-1-r)*DW +: DW];
    end

    for (int c = 0; c < K-1; c++) begin
      cols_d[c] = cols_q[c+1];
    end
    cols_d[K-1] = newCol;

    win_d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_d[(r*K+c)*DW +: DW] = cols_d[c][r*DW +: DW];
      end
    end

    qualify  = (curCol >= ColFirst) && (curRow >= RowFirst);
    winRow_d = curRow - RowFirst;
    winCol_d = curCol - ColFirst;
`ifdef CNN_WIN_STRIDE2_EN
    winValid_d = qualify && !winRow_d[0] && !winCol_d[0];
`else
    winValid_d = qualify;
`endif
    frameEnd = (curRow == RowLast) && (curCol == ColLast);

    // Row wraps at the frame end so consecutive frames need no sof.
    if (curCol == ColLast) begin
      colCnt_d = '0;
      rowCnt_d = (curRow == RowLast) ? '0 : curRow + 1'b1;
    end else begin
      colCnt_d = curCol + 1'b1;
      rowCnt_d = curRow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < K; c++) begin
        cols_q[c] <= '0;
      end
      colCnt_q    <= '0;
      rowCnt_q    <= '0;
      win_q       <= '0;
      winRow_q    <= '0;
      winCol_q    <= '0;
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end else if (in_valid) begin
      for (int c = 0; c < K; c++) begin
        cols_q[c] <= cols_d[c];
      end
      colCnt_q    <= colCnt_d;
      rowCnt_q    <= rowCnt_d;
      winValid_q  <= winValid_d;
      frameDone_q <= frameEnd;
      if (qualify) begin
        win_q    <= win_d;
        winRow_q <= winRow_d;
        winCol_q <= winCol_d;
      end
    end else begin
      winValid_q  <= 1'b0;
      frameDone_q <= 1'b0;
    end
  end

  assign win_valid  = winValid_q;
  assign win        = win_q;
  assign win_row    = winRow_q;
  assign win_col    = winCol_q;
  assign frame_done = frameDone_q;

endmodule
